exc_ctrl: RTL and testbench

//  Exception/interrupt sequencer for the decode stage. Selects between illegal-opcode

---
 rtl/exc_ctrl.sv | 126 ++++++++++++
 tb/tb_exc_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Exception/IRQ sequencer for decode: picks illop vs. synced IRQ and injects the trap only into a safe slot.
// Latency: irq edge -> 2-flop sync -> trap in the first safe cycle; illop traps in the same cycle it is seen.
// Backpressure: stall or an in-flight branch defers injection (ARM); WAIT_K blocks re-trap until kernel entry or timeout.
module exc_ctrl #(
    parameter int          NUM_IRQ       = 4,
    parameter logic [31:0] ILLOP_VEC     = 32'h8000_0004,
    parameter logic [31:0] IRQ_VEC_BASE  = 32'h8000_0008,
    parameter int          ENTRY_TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [31:0]        pc_decode,
    input  logic               op_ill,
    input  logic               stall,
    input  logic               op_br_or_jmp_ex,
    input  logic               op_br_or_jmp_mem,
    output logic               current_exception,
    output logic               preceding_exception,
    output logic [31:0]        exc_vec,
    output logic [3:0]         exc_cause,
    output logic               exc_taken,
    output logic [NUM_IRQ-1:0] irq_ack
);

    localparam int CW = (ENTRY_TIMEOUT > 2) ? $clog2(ENTRY_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ARM, SQUASH, WAIT_K} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_IRQ-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [31:0]        vec_q, vec_d;
    logic [3:0]         cause_q, cause_d;

    logic [NUM_IRQ-1:0] pend;
    logic               safe, req, inject;
    logic [31:0]        win_vec;
    logic [3:0]         win_cause;
    logic [NUM_IRQ-1:0] win_ack;
    logic               pc_unused;

    // Only the kernel-mode bit of the decode PC matters here.
    assign pc_unused = ^pc_decode[30:0];

    always_comb begin
        sync1_d = irq;
        sync2_d = sync1_q;
        pend    = sync2_q & ~{NUM_IRQ{pc_decode[31]}};
        safe    = !stall && !op_br_or_jmp_ex && !op_br_or_jmp_mem;
        req     = op_ill || (|pend);

        win_vec   = '0;
        win_cause = '0;
        win_ack   = '0;
        if (op_ill) begin
            win_vec   = ILLOP_VEC;
            win_cause = 4'd1;
        end else begin
            // Walk from lowest priority upward so irq[0] overwrites last.
            for (int i = NUM_IRQ - 1; i >= 0; i--) begin
                if (pend[i]) begin
                    win_vec    = IRQ_VEC_BASE + 32'(4 * i);
                    win_cause  = 4'(8 + i);
                    win_ack    = '0;
                    win_ack[i] = 1'b1;
                end
            end
        end

        inject  = ((state_q == IDLE) || (state_q == ARM)) && safe && req;
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        cause_d = cause_q;

        case (state_q)
            IDLE, ARM: begin
                if (inject)   state_d = SQUASH;
                else if (req) state_d = ARM;
                else          state_d = IDLE;
            end
            SQUASH: begin
                state_d = WAIT_K;
                cnt_d   = CW'(ENTRY_TIMEOUT - 1);
            end
            WAIT_K: begin
                if (pc_decode[31] || (cnt_q == '0)) state_d = IDLE;
                else                                cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (inject) begin
            vec_d   = win_vec;
            cause_d = win_cause;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            vec_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            vec_q   <= vec_d;
            cause_q <= cause_d;
        end
    end

    // Outputs are forced low while reset is held so nothing escapes mid-sequence.
    assign current_exception   = rst && inject;
    assign exc_taken           = rst && inject;
    assign preceding_exception = rst && (state_q == SQUASH);
    assign exc_vec             = !rst ? '0 : (inject ? win_vec : vec_q);
    assign exc_cause           = !rst ? '0 : (inject ? win_cause : cause_q);
    assign irq_ack             = (rst && inject) ? win_ack : '0;

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed stimulus pushes expected traps; a negedge monitor pops and compares them.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq;
    logic [31:0] pc_decode;
    logic        op_ill, stall, op_br_or_jmp_ex, op_br_or_jmp_mem;
    logic        current_exception, preceding_exception, exc_taken;
    logic [31:0] exc_vec;
    logic [3:0]  exc_cause;
    logic [3:0]  irq_ack;

    exc_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .irq                 (irq),
        .pc_decode           (pc_decode),
        .op_ill              (op_ill),
        .stall               (stall),
        .op_br_or_jmp_ex     (op_br_or_jmp_ex),
        .op_br_or_jmp_mem    (op_br_or_jmp_mem),
        .current_exception   (current_exception),
        .preceding_exception (preceding_exception),
        .exc_vec             (exc_vec),
        .exc_cause           (exc_cause),
        .exc_taken           (exc_taken),
        .irq_ack             (irq_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] vec;
        logic [3:0]  cause;
        logic [3:0]  ack;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   nchk   = 0;
    int   npass  = 0;
    int   ntraps = 0;
    int   last_taken = -10;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int c, input logic [31:0] v, input logic [3:0] ca, input logic [3:0] ak);
        exp_t e;
        e.cyc = c; e.vec = v; e.cause = ca; e.ack = ak;
        q.push_back(e);
    endtask

    // Monitor: every trap must match the head of the scoreboard; SQUASH must follow each trap.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            last_taken = -10;
        end else begin
            if (exc_taken || current_exception)
                chk("cur_vs_taken", {31'b0, current_exception}, {31'b0, exc_taken});
            if (cyc == last_taken + 1)
                chk("squash_follow", {31'b0, preceding_exception}, 32'd1);
            else if (preceding_exception)
                chk("squash_spurious", {31'b0, preceding_exception}, 32'd0);
            if (exc_taken) begin
                ntraps++;
                if (q.size() == 0) begin
                    chk("unexpected_trap_cause", {28'b0, exc_cause}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("trap_cycle", cyc, e.cyc);
                    chk("trap_vec",   exc_vec, e.vec);
                    chk("trap_cause", {28'b0, exc_cause}, {28'b0, e.cause});
                    chk("trap_ack",   {28'b0, irq_ack}, {28'b0, e.ack});
                end
                last_taken = cyc;
            end
        end
    end

    int c;
    int t0;

    initial begin
        rst = 1'b0; irq = '0; pc_decode = 32'h0000_0100;
        op_ill = 1'b0; stall = 1'b0; op_br_or_jmp_ex = 1'b0; op_br_or_jmp_mem = 1'b0;

        // Reset state
        step(2); #2;
        chk("rst_cur",   {31'b0, current_exception}, 32'd0);
        chk("rst_pre",   {31'b0, preceding_exception}, 32'd0);
        chk("rst_taken", {31'b0, exc_taken}, 32'd0);
        chk("rst_vec",   exc_vec, 32'd0);
        chk("rst_cause", {28'b0, exc_cause}, 32'd0);
        chk("rst_ack",   {28'b0, irq_ack}, 32'd0);
        rst = 1'b1;
        step(3);

        // IRQ[2] in user mode: two sync flops, then trap
        c = cyc; irq = 4'b0100;
        push(c + 2, 32'h8000_0010, 4'd10, 4'b0100);
        step(2); #2;
        chk("irq2_cur", {31'b0, current_exception}, 32'd1);
        step(1); irq = '0;
        step(12);
        chk("hold_vec",   exc_vec, 32'h8000_0010);
        chk("hold_cause", {28'b0, exc_cause}, 32'd10);

        // Blocked slot: stall for 3 cycles, then a branch in mem, then safe
        c = cyc; irq = 4'b0001;
        push(c + 6, 32'h8000_0008, 4'd8, 4'b0001);
        step(2); stall = 1'b1;
        step(3); stall = 1'b0; op_br_or_jmp_mem = 1'b1;
        step(1); op_br_or_jmp_mem = 1'b0;
        step(1); irq = '0;
        step(12);

        // Priority: illop beats irq[1:0]; irq[0] retried after kernel exit
        c = cyc; irq = 4'b0011;
        step(2); op_ill = 1'b1;
        push(c + 2, 32'h8000_0004, 4'd1, 4'b0000);
        push(c + 7, 32'h8000_0008, 4'd8, 4'b0001);
        step(1); op_ill = 1'b0;
        step(2); pc_decode = 32'h8000_0100;
        step(2); pc_decode = 32'h0000_0100;
        step(1); irq = '0; pc_decode = 32'h8000_0100;
        step(4);

        // Kernel mask: irq[1] held in kernel mode for 20 cycles
        t0 = ntraps; irq = 4'b0010;
        step(20);
        chk("kernel_mask", ntraps, t0);

        // Timeout: pc stays in user mode, re-trap comes exactly after 8 WAIT_K cycles
        c = cyc; pc_decode = 32'h0000_0100;
        push(c,      32'h8000_000C, 4'd9, 4'b0010);
        push(c + 10, 32'h8000_000C, 4'd9, 4'b0010);
        step(11); irq = '0; pc_decode = 32'h8000_0100;
        step(5);

        // Async reset during an injection cycle
        op_ill = 1'b1; #1;
        chk("pre_rst_taken", {31'b0, exc_taken}, 32'd1);
        rst = 1'b0; #1;
        chk("mid_rst_cur",   {31'b0, current_exception}, 32'd0);
        chk("mid_rst_taken", {31'b0, exc_taken}, 32'd0);
        chk("mid_rst_vec",   exc_vec, 32'd0);
        chk("mid_rst_cause", {28'b0, exc_cause}, 32'd0);
        op_ill = 1'b0;
        step(1); rst = 1'b1;
        step(2);
        chk("post_rst_pre", {31'b0, preceding_exception}, 32'd0);

        // After release the FSM is in IDLE: kernel-mode illop traps at once
        c = cyc; op_ill = 1'b1;
        push(c, 32'h8000_0004, 4'd1, 4'b0000);
        step(1); op_ill = 1'b0;
        step(5);

        chk("scoreboard_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
